icache_resp: RTL and testbench

Responder end of the fetch-stage instruction-memory read interface. It accepts the fetch request (address plus request strobe), serves hits from a small direct-mapped line buffer, and asserts busy on misses. The fetch stage uses busy to hold its PC. On a miss it refills the line from a backing word-wide memory port, then returns the word. It sits between the fetch stage and the instruction memory/bus.

---
 rtl/icache_resp_pkg.sv | 29 ++
 rtl/icache_array.sv | 60 ++++++
 rtl/icache_resp.sv | 177 +++++++++++++++++
 tb/tb_icache_resp.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/icache_resp_pkg.sv
// Shared definitions for the instruction-cache responder: FSM state encoding,
// bus widths and field-width helpers derived from the LINES/WORDS geometry.
package icache_resp_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REFILL  = 2'd1,
    ST_RESPOND = 2'd2
  } state_e;

  // Bits selecting one of LINES direct-mapped lines.
  function automatic int unsigned index_w(input int unsigned lines);
    return $clog2(lines);
  endfunction

  // Bits selecting one 32-bit word within a line.
  function automatic int unsigned word_w(input int unsigned words);
    return $clog2(words);
  endfunction

  // Remaining upper address bits above index, word and byte offset.
  function automatic int unsigned tag_w(input int unsigned lines, input int unsigned words);
    return ADDR_W - index_w(lines) - word_w(words) - 2;
  endfunction

endpackage

// File: rtl/icache_array.sv
// Tag/valid/data storage for the direct-mapped line buffer.
// Ports: clk_i/rst_ni; combinational read (rd_index_i, rd_word_i -> rd_valid_o,
// rd_tag_o, rd_data_o); single-word write (wr_en_i, wr_index_i, wr_word_i,
// wr_data_i); tag write with valid update (tag_we_i, tag_i, set_valid_i) on
// wr_index_i; clear_all_i drops every valid bit.
module icache_array
  import icache_resp_pkg::*;
#(
  parameter int unsigned LINES = 16,
  parameter int unsigned WORDS = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [index_w(LINES)-1:0]     rd_index_i,
  input  logic [word_w(WORDS)-1:0]      rd_word_i,
  output logic                          rd_valid_o,
  output logic [tag_w(LINES,WORDS)-1:0] rd_tag_o,
  output logic [DATA_W-1:0]             rd_data_o,
  input  logic                          wr_en_i,
  input  logic [index_w(LINES)-1:0]     wr_index_i,
  input  logic [word_w(WORDS)-1:0]      wr_word_i,
  input  logic [DATA_W-1:0]             wr_data_i,
  input  logic                          tag_we_i,
  input  logic [tag_w(LINES,WORDS)-1:0] tag_i,
  input  logic                          set_valid_i,
  input  logic                          clear_all_i
);

  localparam int unsigned TAG_W = tag_w(LINES, WORDS);

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [DATA_W-1:0] data_q [LINES][WORDS];

  // Valid bits: only state that needs reset; clear-all wins over a tag write.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
    end else if (clear_all_i) begin
      valid_q <= '0;
    end else if (tag_we_i) begin
      valid_q[wr_index_i] <= set_valid_i;
    end
  end

  // Tag and data payload storage, qualified by the valid bits.
  always_ff @(posedge clk_i) begin
    if (tag_we_i) begin
      tag_q[wr_index_i] <= tag_i;
    end
    if (wr_en_i) begin
      data_q[wr_index_i][wr_word_i] <= wr_data_i;
    end
  end

  assign rd_valid_o = valid_q[rd_index_i];
  assign rd_tag_o   = tag_q[rd_index_i];
  assign rd_data_o  = data_q[rd_index_i][rd_word_i];

endmodule

// File: rtl/icache_resp.sv
// Fetch-side instruction cache responder. Serves hits from a direct-mapped line
// buffer with one-cycle latency, raises o_busy combinationally on a miss and
// refills the whole line one word at a time from the backing memory port.
// Ports: i_clk/i_rst_n; fetch request i_req/i_raddr/i_inval; response
// o_rdata/o_vld/o_busy; backing memory o_mem_ren/o_mem_addr/i_mem_valid/i_mem_rdata.
module icache_resp
  import icache_resp_pkg::*;
#(
  parameter int unsigned LINES = 16,
  parameter int unsigned WORDS = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_raddr,
  input  logic              i_inval,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_vld,
  output logic              o_busy,
  output logic              o_mem_ren,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic              i_mem_valid,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  localparam int unsigned INDEX_W = index_w(LINES);
  localparam int unsigned WORD_W  = word_w(WORDS);
  localparam int unsigned TAG_W   = tag_w(LINES, WORDS);
  localparam int unsigned LINE_W  = ADDR_W - WORD_W - 2;

  state_e              state_q, state_d;
  logic [LINE_W-1:0]   base_q, base_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [WORD_W-1:0]   cnt_q, cnt_d;
  logic                pend_q, pend_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                vld_q, vld_d;
  logic                mem_ren_q, mem_ren_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;

  logic [WORD_W-1:0]   raddr_word;
  logic [INDEX_W-1:0]  raddr_index;
  logic [TAG_W-1:0]    raddr_tag;
  logic [LINE_W-1:0]   raddr_line;
  logic [INDEX_W-1:0]  rd_index;
  logic [WORD_W-1:0]   rd_word;
  logic                rd_valid;
  logic [TAG_W-1:0]    rd_tag;
  logic [DATA_W-1:0]   rd_data;
  logic                arr_wr_en, tag_we, set_valid, clear_all;
  logic                hit_c, miss_c;
  logic                unused_c;

  assign raddr_word  = i_raddr[WORD_W+1:2];
  assign raddr_index = i_raddr[WORD_W+2 +: INDEX_W];
  assign raddr_tag   = i_raddr[ADDR_W-1 -: TAG_W];
  assign raddr_line  = i_raddr[ADDR_W-1 -: LINE_W];
  assign unused_c    = ^i_raddr[1:0];

  // Lookups come from the live address in IDLE, else from the latched miss.
  assign rd_index = (state_q == ST_IDLE) ? raddr_index : base_q[INDEX_W-1:0];
  assign rd_word  = (state_q == ST_IDLE) ? raddr_word  : word_q;

  // A request coinciding with an invalidate is forced down the miss path.
  assign hit_c  = i_req & rd_valid & (rd_tag == raddr_tag);
  assign miss_c = i_req & (~hit_c | i_inval);
  assign o_busy = i_rst_n & ((state_q != ST_IDLE) | miss_c);

  icache_array #(.LINES(LINES), .WORDS(WORDS)) u_array (
    .clk_i       (i_clk),
    .rst_ni      (i_rst_n),
    .rd_index_i  (rd_index),
    .rd_word_i   (rd_word),
    .rd_valid_o  (rd_valid),
    .rd_tag_o    (rd_tag),
    .rd_data_o   (rd_data),
    .wr_en_i     (arr_wr_en),
    .wr_index_i  (base_q[INDEX_W-1:0]),
    .wr_word_i   (cnt_q),
    .wr_data_i   (i_mem_rdata),
    .tag_we_i    (tag_we),
    .tag_i       (base_q[LINE_W-1 -: TAG_W]),
    .set_valid_i (set_valid),
    .clear_all_i (clear_all)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    word_d     = word_q;
    cnt_d      = cnt_q;
    pend_d     = pend_q;
    rdata_d    = rdata_q;
    vld_d      = 1'b0;
    mem_ren_d  = mem_ren_q;
    mem_addr_d = mem_addr_q;
    arr_wr_en  = 1'b0;
    tag_we     = 1'b0;
    set_valid  = 1'b0;
    clear_all  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        clear_all = i_inval;
        if (miss_c) begin
          state_d    = ST_REFILL;
          base_d     = raddr_line;
          word_d     = raddr_word;
          cnt_d      = '0;
          mem_ren_d  = 1'b1;
          mem_addr_d = {raddr_line, (WORD_W+2)'(0)};
        end else if (i_req) begin
          rdata_d = rd_data;
          vld_d   = 1'b1;
        end
      end
      ST_REFILL: begin
        if (i_inval) begin
          pend_d    = 1'b1;
          clear_all = 1'b1;
        end
        if (i_mem_valid) begin
          arr_wr_en = 1'b1;
          cnt_d     = cnt_q + WORD_W'(1);
          if (cnt_q == WORD_W'(WORDS-1)) begin
            // Last beat: address stays on the final word, never past the line.
            mem_ren_d = 1'b0;
            tag_we    = 1'b1;
            set_valid = ~(pend_q | i_inval);
            state_d   = ST_RESPOND;
          end else begin
            mem_addr_d = mem_addr_q + ADDR_W'(4);
          end
        end
      end
      ST_RESPOND: begin
        // Word is returned from the refilled line regardless of its valid bit.
        clear_all = i_inval;
        rdata_d   = rd_data;
        vld_d     = 1'b1;
        pend_d    = 1'b0;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      base_q     <= '0;
      word_q     <= '0;
      cnt_q      <= '0;
      pend_q     <= 1'b0;
      rdata_q    <= '0;
      vld_q      <= 1'b0;
      mem_ren_q  <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      word_q     <= word_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      rdata_q    <= rdata_d;
      vld_q      <= vld_d;
      mem_ren_q  <= mem_ren_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  assign o_rdata    = rdata_q;
  assign o_vld      = vld_q;
  assign o_mem_ren  = mem_ren_q;
  assign o_mem_addr = mem_addr_q;

endmodule

// File: tb/tb_icache_resp.sv
// Directed bench for icache_resp: a backing-memory model answers each read two
// cycles after it appears; expected fetch words and refill addresses are queued
// when requests are issued and checked when the DUT produces them.
module tb_icache_resp;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_req;
  logic [31:0] i_raddr;
  logic        i_inval;
  logic [31:0] o_rdata;
  logic        o_vld;
  logic        o_busy;
  logic        o_mem_ren;
  logic [31:0] o_mem_addr;
  logic        i_mem_valid;
  logic [31:0] i_mem_rdata;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_rsp_q  [$];
  logic [31:0] exp_addr_q [$];

  icache_resp #(.LINES(16), .WORDS(4)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_req       (i_req),
    .i_raddr     (i_raddr),
    .i_inval     (i_inval),
    .o_rdata     (o_rdata),
    .o_vld       (o_vld),
    .o_busy      (o_busy),
    .o_mem_ren   (o_mem_ren),
    .o_mem_addr  (o_mem_addr),
    .i_mem_valid (i_mem_valid),
    .i_mem_rdata (i_mem_rdata)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Backing memory contents: line 0x100 holds 0xA0..0xA3, elsewhere a pattern.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] r;
    if (a[31:4] == 28'h0000010) r = 32'hA0 + 32'(a[3:2]);
    else                        r = a ^ 32'hC0DE_0000;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic push_line(input logic [31:0] addr);
    logic [31:0] base;
    base = addr & 32'hFFFF_FFF0;
    for (int w = 0; w < 4; w++) exp_addr_q.push_back(base + 32'(w * 4));
  endtask

  // Memory responder: one beat at a time, data valid two cycles after the read.
  initial begin
    int cnt;
    cnt = 0;
    i_mem_valid = 1'b0;
    i_mem_rdata = '0;
    forever begin
      @(posedge i_clk);
      #2;
      if (!i_rst_n || i_mem_valid) begin
        i_mem_valid = 1'b0;
        cnt = 0;
      end else if (o_mem_ren) begin
        cnt++;
        if (cnt == 2) begin
          if (exp_addr_q.size() == 0) chk("mem_unexpected_read", 32'(exp_addr_q.size()), 32'd1);
          else chk("mem_addr", o_mem_addr, exp_addr_q.pop_front());
          i_mem_rdata = mem_word(o_mem_addr);
          i_mem_valid = 1'b1;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Response scoreboard: every o_vld must match the oldest queued fetch.
  always @(negedge i_clk) begin
    if (i_rst_n && o_vld) begin
      if (exp_rsp_q.size() == 0) chk("unexpected_vld", {31'b0, o_vld}, 32'd0);
      else chk("rdata", o_rdata, exp_rsp_q.pop_front());
    end
  end

  // Hold the request until o_vld, busy asserted on every cycle before it.
  task automatic wait_vld(input string tag);
    int n;
    n = 0;
    do begin
      tick();
      i_inval = 1'b0;
      n++;
      if (!o_vld) chk({tag, "_busy_hold"}, {31'b0, o_busy}, 32'd1);
    end while (!o_vld && n < 100);
    chk({tag, "_vld"}, {31'b0, o_vld}, 32'd1);
    i_req = 1'b0;
    #1;
    chk({tag, "_busy_after"}, {31'b0, o_busy}, 32'd0);
  endtask

  task automatic do_miss(input logic [31:0] addr, input logic inv, input string tag);
    tick();
    push_line(addr);
    exp_rsp_q.push_back(mem_word(addr));
    i_req   = 1'b1;
    i_raddr = addr;
    i_inval = inv;
    #1;
    chk({tag, "_busy_miss"}, {31'b0, o_busy}, 32'd1);
    wait_vld(tag);
  endtask

  task automatic do_hit(input logic [31:0] addr, input string tag);
    tick();
    exp_rsp_q.push_back(mem_word(addr));
    i_req   = 1'b1;
    i_raddr = addr;
    #1;
    chk({tag, "_busy_hit"}, {31'b0, o_busy}, 32'd0);
    tick();
    chk({tag, "_vld"}, {31'b0, o_vld}, 32'd1);
    chk({tag, "_no_ren"}, {31'b0, o_mem_ren}, 32'd0);
    i_req = 1'b0;
  endtask

  initial begin
    int n;
    // Reset with a live request: busy must stay low while in reset.
    i_rst_n = 1'b0;
    i_req   = 1'b1;
    i_raddr = 32'h100;
    i_inval = 1'b0;
    #13;
    chk("rst_busy", {31'b0, o_busy}, 32'd0);
    chk("rst_vld", {31'b0, o_vld}, 32'd0);
    chk("rst_rdata", o_rdata, 32'd0);
    chk("rst_ren", {31'b0, o_mem_ren}, 32'd0);
    chk("rst_maddr", o_mem_addr, 32'd0);
    i_req = 1'b0;
    #7;
    i_rst_n = 1'b1;

    // Cold miss, hit, conflict eviction.
    do_miss(32'h100, 1'b0, "cold100");
    do_hit(32'h108, "hit108");
    do_miss(32'h200, 1'b0, "evict200");
    do_miss(32'h100, 1'b0, "remiss100");
    do_hit(32'h10C, "hit10C");
    do_miss(32'h1F0, 1'b0, "fill1F0");
    do_hit(32'h1F4, "hit1F4");

    // Invalidate in IDLE with a coincident hit: taken as a miss, clears all.
    do_miss(32'h1F4, 1'b1, "idle_inval");
    do_miss(32'h100, 1'b0, "post_idle_inval");
    do_hit(32'h1F8, "hit1F8");

    // Invalidate on the second refill beat of 0x300.
    tick();
    push_line(32'h300);
    exp_rsp_q.push_back(mem_word(32'h300));
    i_req   = 1'b1;
    i_raddr = 32'h300;
    #1;
    chk("inval300_busy_miss", {31'b0, o_busy}, 32'd1);
    n = 0;
    while (exp_addr_q.size() > 2 && n < 100) begin
      tick();
      n++;
    end
    chk("inval300_beat2", 32'(exp_addr_q.size()), 32'd2);
    i_inval = 1'b1;
    wait_vld("inval300");
    do_miss(32'h300, 1'b0, "after_inval300");
    do_miss(32'h1F4, 1'b0, "after_inval1F4");
    do_miss(32'h108, 1'b0, "after_inval108");

    // Reset asserted after the first beat of a refill.
    tick();
    push_line(32'h500);
    exp_rsp_q.push_back(mem_word(32'h500));
    i_req   = 1'b1;
    i_raddr = 32'h500;
    n = 0;
    while (exp_addr_q.size() > 3 && n < 100) begin
      tick();
      n++;
    end
    chk("rstmid_beat1", 32'(exp_addr_q.size()), 32'd3);
    tick();
    i_rst_n = 1'b0;
    #1;
    chk("rstmid_ren", {31'b0, o_mem_ren}, 32'd0);
    chk("rstmid_vld", {31'b0, o_vld}, 32'd0);
    chk("rstmid_busy", {31'b0, o_busy}, 32'd0);
    exp_addr_q.delete();
    exp_rsp_q.delete();
    i_req = 1'b0;
    tick();
    tick();
    i_rst_n = 1'b1;
    do_miss(32'h500, 1'b0, "post_rst500");

    // Top-of-memory line: addresses must stop at 0xFFFFFFFC.
    do_miss(32'hFFFF_FFF8, 1'b0, "wrap");

    repeat (6) tick();
    chk("end_ren", {31'b0, o_mem_ren}, 32'd0);
    chk("addr_q_left", 32'(exp_addr_q.size()), 32'd0);
    chk("rsp_q_left", 32'(exp_rsp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
